mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised memory access unit that sits between the multicycle CPU control/datapath and the memory port. It takes one load or store request at a time, performs byte-lane steering and byte enables, sign/zero extends byte loads, and holds the memory strobes until the memory handshake completes. It also flags misaligned word accesses and memory timeouts. It replaces the fixed 16-bit MAR/MDR/byte-extension path with a single handshaked block that is generic in word width.

## Interface
- WIDTH, 16, data word width in bits; one of 16, 32, 64. LANES = WIDTH/8, LSB = log2(LANES).
- ADDR_WIDTH, 16, byte address width.
- MAX_WAIT, 255, maximum ACCESS cycles before timeout; 0 disables the timeout.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = full-word access.
- req_signed  in  1  byte loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  WIDTH  store data; byte stores use bits [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WIDTH  load result; 0 for stores and errors.
- resp_err  out  1  misaligned access or timeout; valid with resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_WIDTH  word-aligned address {req_addr[ADDR_WIDTH-1:LSB], LSB'b0}.
- mem_wdata  out  WIDTH  steered store data.
- mem_byte_enable  out  LANES  active lanes.
- mem_rdata  in  WIDTH  memory read data, sampled on mem_resp.
- mem_resp  in  1  memory completion.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. The state and every request field are registered.
- IDLE: req_ready=1. A request is accepted on the edge where req_valid=1, and all req_* fields are latched.
  - A word access with req_addr[LSB-1:0] != 0 is misaligned. It goes to RESP with err=1 and no memory operation occurs.
  - Any other request goes to ACCESS.
- ACCESS: mem_read is driven as !write and mem_write as write. All mem_* outputs are driven from latched registers and stay stable for the whole state.
  - Byte lane k = addr[LSB-1:0]. mem_byte_enable is one-hot at bit k for byte accesses and all ones for word accesses. Loads drive byte_enable the same way.
  - Byte store: mem_wdata = wdata[7:0] replicated across all lanes. Word store: mem_wdata = wdata.
  - The wait counter resets to 0 on entry and increments each ACCESS cycle without mem_resp.
  - On mem_resp=1: the load result is latched and the FSM goes to RESP with err=0.
    - Word loads return mem_rdata.
    - Byte loads return mem_rdata[8k+7:8k], sign- or zero-extended to WIDTH.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT-1 with no mem_resp, the FSM goes to RESP with err=1 and rdata=0.
  - If mem_resp and timeout occur in the same cycle, mem_resp wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no backpressure on the response.
- resp_rdata and resp_err hold their last value until the next RESP.
- mem_resp is ignored outside ACCESS.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, counter=0.
- Reset asserted in any state:
  - Strobes drop asynchronously.
  - No response is ever issued for the aborted request.
  - Requests presented while reset is high are dropped.

## Timing
- Accept edge at cycle N. ACCESS strobes are high from cycle N+1.
- mem_resp seen in cycle M gives resp_valid in cycle M+1. The next accept is possible in cycle M+2.
- Minimum latency, accept to resp_valid: 2 cycles (mem_resp in N+1).
- Misaligned request: resp_valid in cycle N+1, no strobe ever asserted.
- Timeout: the strobe is high for exactly MAX_WAIT cycles, then resp_valid/err appear in the next cycle.
- Combinational paths: none from mem_rdata/mem_resp to any output. req_ready is decoded from the state register only.

## Test plan
- WIDTH=16, word load at 0x1234, mem_resp after 3 wait cycles with mem_rdata=0xBEEF:
  - mem_address=0x1234, byte_enable=2'b11, mem_read high for 4 cycles.
  - resp_valid for one cycle after mem_resp, rdata=0xBEEF, err=0.
- Byte load at 0x1235 with mem_rdata=0x80FF:
  - mem_address=0x1234, byte_enable=2'b10.
  - signed gives resp_rdata=0xFF80; unsigned gives 0x0080.
  - Same test at 0x1234 signed gives 0xFFFF.
- Byte store at 0x2001, wdata=0x12A5:
  - mem_wdata=0xA5A5, byte_enable=2'b10, mem_write held until mem_resp, resp_rdata=0.
  - WIDTH=32 at 0x2003: byte_enable=4'b1000, mem_wdata=0xA5A5A5A5.
- Word load at 0x0003: mem_read never asserted; resp_valid=1, err=1 in the cycle after accept; req_ready returns the cycle after.
- MAX_WAIT=4, no mem_resp: mem_read high exactly 4 cycles, then resp_valid=1, err=1, rdata=0. A mem_resp arriving in cycle 4 instead gives err=0.
- Reset pulsed mid-ACCESS:
  - mem_read drops before the next edge, no resp_valid, req_ready=1.
  - A stray mem_resp afterwards is ignored.
  - A back-to-back request then completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundle of the CPU request/response channel and the memory port of mem_access_unit.
interface mem_access_unit_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
);
  localparam int LANES = WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_byte;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  resp_valid;
  logic [WIDTH-1:0]      resp_rdata;
  logic                  resp_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [WIDTH-1:0]      mem_wdata;
  logic [LANES-1:0]      mem_byte_enable;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_resp;

  // Access-unit side.
  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp
  );

  // CPU and memory side.
  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: one load/store at a time, byte-lane steering, byte
// enables, byte-load extension, misalign and timeout errors.

// One byte lane: enable, store steering and load byte select.
module mau_lane (
  input  logic       active,
  input  logic       is_byte,
  input  logic       sel,
  input  logic [7:0] wbyte,
  input  logic [7:0] wlane,
  input  logic [7:0] rlane,
  output logic       be,
  output logic [7:0] wd,
  output logic [7:0] rd
);
  assign be = active & (~is_byte | sel);
  assign wd = active ? (is_byte ? wbyte : wlane) : 8'h00;
  assign rd = sel ? rlane : 8'h00;
endmodule

module mem_access_unit #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 255
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);
  localparam int LANES   = WIDTH / 8;
  localparam int LSB     = $clog2(LANES);
  localparam int TO_LAST = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
  localparam int CW      = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic                  is_byte;
    logic                  sgn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
  } req_t;

  state_t                state, state_nx;
  req_t                  req_q;
  logic [CW-1:0]         cnt_q;
  logic [WIDTH-1:0]      rdata_q, rdata_nx;
  logic                  err_q, err_nx;
  logic                  accept, misaligned, in_access, timeout;
  logic [LSB-1:0]        lane;
  logic [LANES-1:0]      be;
  logic [LANES-1:0][7:0] wd, rd;
  logic [7:0]            rbyte;
  logic [WIDTH-1:0]      load_val;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign misaligned = !bus.req_byte && (bus.req_addr[LSB-1:0] != '0);
  assign in_access  = (state == ACCESS);
  assign lane       = req_q.addr[LSB-1:0];

  // Timeout fires on the last allowed ACCESS cycle; mem_resp has priority.
  generate
    if (MAX_WAIT > 0) begin : g_to
      assign timeout = in_access && !bus.mem_resp && (cnt_q == CW'(TO_LAST));
    end else begin : g_noto
      assign timeout = 1'b0;
    end
  endgenerate

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      mau_lane u_lane (
        .active  (in_access),
        .is_byte (req_q.is_byte),
        .sel     (lane == LSB'(k)),
        .wbyte   (req_q.wdata[7:0]),
        .wlane   (req_q.wdata[8*k +: 8]),
        .rlane   (bus.mem_rdata[8*k +: 8]),
        .be      (be[k]),
        .wd      (wd[k]),
        .rd      (rd[k])
      );
    end
  endgenerate

  // Collapse the lane-selected read bytes; only one lane is ever selected.
  always_comb begin
    rbyte = 8'h00;
    for (int k = 0; k < LANES; k++) rbyte = rbyte | rd[k];
  end

  // Load result: full word, or the selected byte sign/zero extended.
  always_comb begin
    if (req_q.is_byte) load_val = {{(WIDTH-8){req_q.sgn & rbyte[7]}}, rbyte};
    else               load_val = bus.mem_rdata;
  end

  // Next state and the response value captured on entry to RESP.
  always_comb begin
    state_nx = state;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned) begin
            state_nx = RESP;
            rdata_nx = '0;
            err_nx   = 1'b1;
          end else begin
            state_nx = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_resp) begin
          state_nx = RESP;
          rdata_nx = req_q.write ? '0 : load_val;
          err_nx   = 1'b0;
        end else if (timeout) begin
          state_nx = RESP;
          rdata_nx = '0;
          err_nx   = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset aborts any request without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Latch every request field on accept; mem_* outputs derive from these.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.write   <= bus.req_write;
      req_q.is_byte <= bus.req_byte;
      req_q.sgn     <= bus.req_signed;
      req_q.addr    <= bus.req_addr;
      req_q.wdata   <= bus.req_wdata;
    end
  end

  // Wait counter: cleared on accept, counts ACCESS cycles without mem_resp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt_q <= '0;
    else if (accept)                    cnt_q <= '0;
    else if (in_access && !bus.mem_resp) cnt_q <= cnt_q + 1'b1;
  end

  // Response data and error hold until the next RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.req_ready       = (state == IDLE);
  assign bus.resp_valid      = (state == RESP);
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_err        = err_q;
  assign bus.mem_read        = in_access & ~req_q.write;
  assign bus.mem_write       = in_access &  req_q.write;
  assign bus.mem_address     = {req_q.addr[ADDR_WIDTH-1:LSB], LSB'(0)};
  assign bus.mem_wdata       = wd;
  assign bus.mem_byte_enable = be;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 16-bit unit with MAX_WAIT=4 and a 32-bit unit
// with the timeout disabled, directed cases followed by random transactions.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.WIDTH(16), .ADDR_WIDTH(16)) i16 ();
  mem_access_unit_if #(.WIDTH(32), .ADDR_WIDTH(16)) i32 ();

  mem_access_unit #(.WIDTH(16), .ADDR_WIDTH(16), .MAX_WAIT(4)) dut16 (
    .clk(clk), .reset(reset), .bus(i16));
  mem_access_unit #(.WIDTH(32), .ADDR_WIDTH(16), .MAX_WAIT(0)) dut32 (
    .clk(clk), .reset(reset), .bus(i32));

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct packed {
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] resp_rdata;
    logic [31:0] mem_wdata;
    logic [15:0] mem_address;
    logic [3:0]  be;
  } obs_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t snap(input bit w);
    obs_t o;
    if (w) begin
      o.req_ready = i32.req_ready;    o.resp_valid = i32.resp_valid;
      o.resp_err = i32.resp_err;      o.mem_read = i32.mem_read;
      o.mem_write = i32.mem_write;    o.resp_rdata = i32.resp_rdata;
      o.mem_wdata = i32.mem_wdata;    o.mem_address = i32.mem_address;
      o.be = i32.mem_byte_enable;
    end else begin
      o.req_ready = i16.req_ready;    o.resp_valid = i16.resp_valid;
      o.resp_err = i16.resp_err;      o.mem_read = i16.mem_read;
      o.mem_write = i16.mem_write;    o.resp_rdata = 32'(i16.resp_rdata);
      o.mem_wdata = 32'(i16.mem_wdata); o.mem_address = i16.mem_address;
      o.be = 4'(i16.mem_byte_enable);
    end
    return o;
  endfunction

  task automatic drive_req(input bit w, input bit v, input bit wr, input bit by,
                           input bit sg, input logic [15:0] a, input logic [31:0] d);
    i16.req_valid = v & ~w;  i32.req_valid = v & w;
    i16.req_write = wr;      i32.req_write = wr;
    i16.req_byte = by;       i32.req_byte = by;
    i16.req_signed = sg;     i32.req_signed = sg;
    i16.req_addr = a;        i32.req_addr = a;
    i16.req_wdata = d[15:0]; i32.req_wdata = d;
  endtask

  task automatic drive_mem(input bit w, input bit r, input logic [31:0] d);
    i16.mem_resp = r & ~w;   i32.mem_resp = r & w;
    i16.mem_rdata = d[15:0]; i32.mem_rdata = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction with expectations derived from the access rules.
  task automatic txn(input string nm, input bit w, input bit wr, input bit by, input bit sg,
                     input logic [15:0] a, input logic [31:0] d, input logic [31:0] md,
                     input int waitc);
    int lanes, maxw, k, c;
    bit mis, done, exp_err;
    logic [31:0] mask, exp_be, exp_wd, exp_rd, b;
    obs_t o;
    lanes  = w ? 4 : 2;
    maxw   = w ? 0 : 4;
    k      = int'(a) % lanes;
    mask   = w ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    mis    = !by && (k != 0);
    exp_be = by ? (32'd1 << k) : ((32'd1 << lanes) - 32'd1);
    exp_wd = by ? (32'(d[7:0]) * (w ? 32'h0101_0101 : 32'h0000_0101)) : (d & mask);
    b      = (md >> (8 * k)) & 32'hFF;
    exp_rd = by ? ((sg && b[7]) ? (b | (mask & ~32'hFF)) : b) : (md & mask);
    exp_err = 1'b0;
    o = snap(w);
    chk({nm, ".ready"}, 64'(o.req_ready), 64'(1));
    drive_req(w, 1'b1, wr, by, sg, a, d);
    tick;
    drive_req(w, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    if (mis) begin
      exp_err = 1'b1;
      exp_rd  = 32'h0;
    end else begin
      c = 0;
      done = 1'b0;
      while (!done) begin
        drive_mem(w, c == waitc, md);
        o = snap(w);
        chk({nm, ".mem_read"}, 64'(o.mem_read), 64'(!wr));
        chk({nm, ".mem_write"}, 64'(o.mem_write), 64'(wr));
        chk({nm, ".addr"}, 64'(o.mem_address), 64'(a & ~16'(lanes - 1)));
        chk({nm, ".be"}, 64'(o.be), 64'(exp_be));
        if (wr) chk({nm, ".wdata"}, 64'(o.mem_wdata), 64'(exp_wd));
        chk({nm, ".busy_valid"}, 64'(o.resp_valid), 64'(0));
        tick;
        drive_mem(w, 1'b0, 32'h0);
        if (c == waitc) done = 1'b1;
        else if (maxw > 0 && c == maxw - 1) begin
          done = 1'b1;
          exp_err = 1'b1;
        end
        c++;
        if (c > 64) done = 1'b1;
      end
      if (wr || exp_err) exp_rd = 32'h0;
    end
    o = snap(w);
    chk({nm, ".resp_valid"}, 64'(o.resp_valid), 64'(1));
    chk({nm, ".resp_err"}, 64'(o.resp_err), 64'(exp_err));
    chk({nm, ".resp_rdata"}, 64'(o.resp_rdata), 64'(exp_rd));
    chk({nm, ".resp_strobe"}, 64'({o.mem_read, o.mem_write}), 64'(0));
    tick;
    o = snap(w);
    chk({nm, ".valid_drop"}, 64'(o.resp_valid), 64'(0));
    chk({nm, ".ready_back"}, 64'(o.req_ready), 64'(1));
    chk({nm, ".rdata_hold"}, 64'(o.resp_rdata), 64'(exp_rd));
    chk({nm, ".err_hold"}, 64'(o.resp_err), 64'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive_mem(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    tick;
    tick;
    for (int w = 0; w < 2; w++) begin
      o = snap(w[0]);
      chk("rst.ready", 64'(o.req_ready), 64'(1));
      chk("rst.valid", 64'(o.resp_valid), 64'(0));
      chk("rst.err", 64'(o.resp_err), 64'(0));
      chk("rst.rdata", 64'(o.resp_rdata), 64'(0));
      chk("rst.strobes", 64'({o.mem_read, o.mem_write}), 64'(0));
      chk("rst.addr", 64'(o.mem_address), 64'(0));
      chk("rst.wdata", 64'(o.mem_wdata), 64'(0));
      chk("rst.be", 64'(o.be), 64'(0));
    end
    reset = 1'b0;
    tick;

    txn("wload",    1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0,    32'hBEEF, 3);
    txn("bload_s",  1'b0, 1'b0, 1'b1, 1'b1, 16'h1235, 32'h0,    32'h80FF, 1);
    txn("bload_u",  1'b0, 1'b0, 1'b1, 1'b0, 16'h1235, 32'h0,    32'h80FF, 0);
    txn("bload_s0", 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 32'h0,    32'h80FF, 2);
    txn("bstore",   1'b0, 1'b1, 1'b1, 1'b0, 16'h2001, 32'h12A5, 32'h0,    2);
    txn("bstore32", 1'b1, 1'b1, 1'b1, 1'b0, 16'h2003, 32'h12A5, 32'h0,    1);
    txn("wstore32", 1'b1, 1'b1, 1'b0, 1'b0, 16'h4008, 32'hCAFE_F00D, 32'h0, 6);
    txn("misalign", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 32'h0,    32'h0,    0);
    txn("timeout",  1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0,    32'h1111, 99);
    txn("lastresp", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0,    32'h2222, 3);

    // Reset during ACCESS: strobe drops at once, no response, stray mem_resp ignored.
    drive_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 32'h0);
    tick;
    drive_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 32'h0);
    o = snap(1'b0);
    chk("arst.pre_read", 64'(o.mem_read), 64'(1));
    #1 reset = 1'b1;
    #1 o = snap(1'b0);
    chk("arst.read_drop", 64'(o.mem_read), 64'(0));
    chk("arst.valid", 64'(o.resp_valid), 64'(0));
    chk("arst.ready", 64'(o.req_ready), 64'(1));
    tick;
    tick;
    reset = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    o = snap(1'b0);
    chk("arst.rdata_clr", 64'(o.resp_rdata), 64'(0));
    drive_mem(1'b0, 1'b1, 32'hDEAD);
    tick;
    drive_mem(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      o = snap(1'b0);
      chk("stray.valid", 64'(o.resp_valid), 64'(0));
      chk("stray.read", 64'(o.mem_read), 64'(0));
      chk("stray.ready", 64'(o.req_ready), 64'(1));
      if (i == 0) tick;
    end
    txn("b2b0", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 32'h0,    32'h1357, 0);
    txn("b2b1", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0102, 32'h9ABC, 32'h0,    0);

    for (int i = 0; i < 40; i++) begin
      bit w, wr, by, sg;
      logic [15:0] a;
      logic [31:0] d, md;
      int wc;
      w  = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      by = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      d  = $urandom;
      md = $urandom;
      wc = w ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 5));
      txn("rnd", w, wr, by, sg, a, d, md, wc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
